// File: rtl/dmem_ctrl.sv
// Data-RAM sequencer for the RV32IC MEM stage: sub-word loads/stores via word accesses,
// read-modify-write for byte/half stores, and a boot/debug loader write port sharing the RAM.
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH+1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_misaligned,
    input  logic                  i_ld_req,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    input  logic [DATA_WIDTH-1:0] i_ld_wdata,
    output logic                  o_ld_gnt,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    // state     | meaning
    // IDLE      | accept loader write or new core op; word stores and misaligned ops finish here
    // RD_WAIT   | RAM read data arriving; extract lane, extend, register result
    // LD_DONE   | load result valid, pipeline released
    // RMW_MERGE | RAM read data arriving; splice store byte/half into the word
    // RMW_WR    | write merged word back, pipeline released
    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        LD_DONE,
        RMW_MERGE,
        RMW_WR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cap_waddr_q;
    logic [1:0]              cap_lane_q;
    logic [1:0]              cap_size_q;
    logic                    cap_uns_q;
    logic [15:0]             cap_wdata_q;
    logic [DATA_WIDTH-1:0]   merge_q, merge_d;
    logic [DATA_WIDTH-1:0]   rdata_q, ld_ext;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;

    logic [ADDR_WIDTH-1:0]   req_waddr;
    logic                    req_word, req_half, req_mis, cap_en;

    assign req_waddr = i_addr[ADDR_WIDTH+1:2];
    assign req_word  = i_size[1];
    assign req_half  = (i_size == 2'b01);
    assign req_mis   = (req_half & i_addr[0]) | (req_word & (|i_addr[1:0]));
    assign cap_en    = (state_q == IDLE) & i_req & ~i_ld_req;

    always_comb begin
        lane_byte = i_mem_rdata[{cap_lane_q, 3'b000} +: 8];
        lane_half = cap_lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        if (cap_size_q[1])
            ld_ext = i_mem_rdata;
        else if (cap_size_q[0])
            ld_ext = {{16{lane_half[15] & ~cap_uns_q}}, lane_half};
        else
            ld_ext = {{24{lane_byte[7] & ~cap_uns_q}}, lane_byte};
    end

    always_comb begin
        merge_d = i_mem_rdata;
        if (cap_size_q == 2'b01) begin
            if (cap_lane_q[1])
                merge_d[31:16] = cap_wdata_q;
            else
                merge_d[15:0] = cap_wdata_q;
        end else begin
            merge_d[{cap_lane_q, 3'b000} +: 8] = cap_wdata_q[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        o_ld_gnt     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = cap_waddr_q;
        o_mem_wdata  = merge_q;
        // Strobes are forced low while reset is asserted, whatever the inputs do.
        if (i_rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (i_ld_req) begin
                        o_mem_we    = 1'b1;
                        o_mem_addr  = i_ld_addr;
                        o_mem_wdata = i_ld_wdata;
                        o_ld_gnt    = 1'b1;
                        o_stall     = i_req;
                    end else if (i_req) begin
                        if (req_mis) begin
                            o_misaligned = 1'b1;
                        end else if (i_we && req_word) begin
                            o_mem_we    = 1'b1;
                            o_mem_addr  = req_waddr;
                            o_mem_wdata = i_wdata;
                        end else begin
                            o_mem_addr = req_waddr;
                            o_stall    = 1'b1;
                            state_d    = i_we ? RMW_MERGE : RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    o_stall = 1'b1;
                    state_d = LD_DONE;
                end
                LD_DONE: begin
                    state_d = IDLE;
                end
                RMW_MERGE: begin
                    o_stall = 1'b1;
                    state_d = RMW_WR;
                end
                RMW_WR: begin
                    o_mem_we = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_rvalid = (state_q == LD_DONE);
    assign o_rdata  = rdata_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cap_waddr_q <= '0;
            cap_lane_q  <= '0;
            cap_size_q  <= '0;
            cap_uns_q   <= 1'b0;
            cap_wdata_q <= '0;
            merge_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                cap_waddr_q <= req_waddr;
                cap_lane_q  <= i_addr[1:0];
                cap_size_q  <= i_size;
                cap_uns_q   <= i_unsigned;
                cap_wdata_q <= i_wdata[15:0];
            end
            if (state_q == RD_WAIT)
                rdata_q <= ld_ext;
            if (state_q == RMW_MERGE)
                merge_q <= merge_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level memory model plus per-cycle compare.
module tb_dmem_ctrl;
    localparam int AW = 9;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_req = 1'b0, i_we = 1'b0, i_unsigned = 1'b0;
    logic [AW+1:0] i_addr = '0;
    logic [1:0]    i_size = '0;
    logic [31:0]   i_wdata = '0;
    logic          o_stall, o_rvalid, o_misaligned, o_ld_gnt, o_mem_we;
    logic [31:0]   o_rdata, o_mem_wdata;
    logic          i_ld_req = 1'b0;
    logic [AW-1:0] i_ld_addr = '0;
    logic [31:0]   i_ld_wdata = '0;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   i_mem_rdata;

    dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_size(i_size), .i_unsigned(i_unsigned), .i_wdata(i_wdata), .o_stall(o_stall),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_misaligned(o_misaligned),
        .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_wdata(i_ld_wdata),
        .o_ld_gnt(o_ld_gnt), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Registered single-port RAM, read-before-write
    logic [31:0] ram [0:511];
    always @(posedge i_clk) begin
        i_mem_rdata <= ram[o_mem_addr];
        if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
    end

    int n_tests = 0, n_fail = 0;
    logic [31:0]   ref_mem [0:511];
    logic [31:0]   exp_rd [$];
    logic [AW-1:0] exp_wa [$];
    logic [31:0]   exp_wd [$];
    int            exp_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s unexpected event, actual=%h required=none", nm, act);
    endtask

    function automatic logic is_mis(input logic [AW+1:0] a, input logic [1:0] sz);
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int bits;
        if (sz[1]) return w;
        bits = (sz == 2'b00) ? 8 : 16;
        v = (w >> (8 * lane)) & ((32'd1 << bits) - 32'd1);
        if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        if (sz[1]) return wd;
        mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * lane);
        return (w & ~mask) | ((wd << (8 * lane)) & mask);
    endfunction

    task automatic model_op(input logic we, input logic [AW+1:0] a, input logic [1:0] sz,
                            input logic uns, input logic [31:0] wd);
        logic [AW-1:0] wa;
        logic [31:0] nv;
        wa = a[AW+1:2];
        if (is_mis(a, sz)) begin
            exp_mis++;
        end else if (!we) begin
            exp_rd.push_back(load_val(ref_mem[wa], a[1:0], sz, uns));
        end else begin
            nv = store_val(ref_mem[wa], a[1:0], sz, wd);
            ref_mem[wa] = nv;
            exp_wa.push_back(wa);
            exp_wd.push_back(nv);
        end
    endtask

    task automatic model_ld(input logic [AW-1:0] wa, input logic [31:0] d);
        ref_mem[wa] = d;
        exp_wa.push_back(wa);
        exp_wd.push_back(d);
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_rvalid) begin
                if (exp_rd.size() == 0) unexpected("rvalid", o_rdata);
                else chk("rdata", o_rdata, exp_rd.pop_front());
            end
            if (o_mem_we) begin
                if (exp_wa.size() == 0) unexpected("mem_we", o_mem_wdata);
                else begin
                    chk("mem_addr", 32'(o_mem_addr), 32'(exp_wa.pop_front()));
                    chk("mem_wdata", o_mem_wdata, exp_wd.pop_front());
                end
            end
            if (o_misaligned) begin
                if (exp_mis == 0) unexpected("misaligned", 32'd1);
                else exp_mis--;
            end
        end
    end

    task automatic op(input logic we, input logic [AW+1:0] a, input logic [1:0] sz,
                      input logic uns, input logic [31:0] wd, input int exp_st,
                      output logic [31:0] rd);
        int st_cnt = 0, mis_cnt = 0;
        logic st;
        bit done = 0;
        model_op(we, a, sz, uns, wd);
        rd = o_rdata;
        i_req = 1'b1; i_we = we; i_addr = a; i_size = sz; i_unsigned = uns; i_wdata = wd;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge i_clk);
            st = o_stall;
            if (o_misaligned) mis_cnt++;
            if (o_rvalid) rd = o_rdata;
            @(posedge i_clk);
            #1;
            if (st) st_cnt++;
            else done = 1;
        end
        i_req = 1'b0; i_we = 1'b0;
        chk("op_completes", 32'(done), 32'd1);
        chk("stall_cycles", st_cnt, exp_st);
        chk("misaligned_pulses", mis_cnt, is_mis(a, sz) ? 1 : 0);
    endtask

    task automatic ld_drive(input logic [AW-1:0] wa, input logic [31:0] d, input int exp_wait);
        int wait_cnt = 0;
        logic g;
        bit done = 0;
        i_ld_req = 1'b1; i_ld_addr = wa; i_ld_wdata = d;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge i_clk);
            g = o_ld_gnt;
            @(posedge i_clk);
            #1;
            if (g) done = 1;
            else wait_cnt++;
        end
        i_ld_req = 1'b0;
        chk("ld_granted", 32'(done), 32'd1);
        chk("ld_wait_cycles", wait_cnt, exp_wait);
    endtask

    task automatic ld(input logic [AW-1:0] wa, input logic [31:0] d);
        model_ld(wa, d);
        ld_drive(wa, d, 0);
    endtask

    logic [31:0] rd, rd2;

    initial begin
        #12;
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_strobes", {28'h0, o_rvalid, o_misaligned, o_ld_gnt, o_mem_we}, 32'h0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        ld(9'd3, 32'h8899_AABB);
        op(1'b0, 11'h00E, 2'b00, 1'b0, 32'h0, 2, rd); chk("lb_lit", rd, 32'hFFFF_FF99);
        op(1'b0, 11'h00E, 2'b00, 1'b1, 32'h0, 2, rd); chk("lbu_lit", rd, 32'h0000_0099);
        op(1'b0, 11'h00C, 2'b01, 1'b0, 32'h0, 2, rd); chk("lh_lit", rd, 32'hFFFF_AABB);
        op(1'b0, 11'h00E, 2'b01, 1'b1, 32'h0, 2, rd); chk("lhu_lit", rd, 32'h0000_8899);
        op(1'b0, 11'h00D, 2'b00, 1'b0, 32'h0, 2, rd); chk("lb_lane1", rd, 32'hFFFF_FFAA);

        ld(9'd3, 32'h1122_3344);
        op(1'b1, 11'h00E, 2'b01, 1'b0, 32'h0000_BEEF, 2, rd);
        op(1'b0, 11'h00C, 2'b10, 1'b0, 32'h0, 2, rd); chk("sh_lw_lit", rd, 32'hBEEF_3344);

        op(1'b1, 11'h010, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, rd2);
        chk("rdata_hold", o_rdata, 32'hBEEF_3344);
        op(1'b0, 11'h010, 2'b11, 1'b1, 32'h0, 2, rd); chk("sw_lw_lit", rd, 32'hDEAD_BEEF);

        op(1'b0, 11'h001, 2'b01, 1'b0, 32'h0, 0, rd2);
        op(1'b1, 11'h012, 2'b10, 1'b0, 32'h1234_5678, 0, rd2);
        op(1'b0, 11'h010, 2'b10, 1'b0, 32'h0, 2, rd); chk("mis_sw_nowrite", rd, 32'hDEAD_BEEF);

        fork
            op(1'b1, 11'h00D, 2'b00, 1'b0, 32'h0000_00A5, 2, rd2);
            begin
                @(posedge i_clk);
                #1;
                model_ld(9'd5, 32'hCAFE_F00D);
                ld_drive(9'd5, 32'hCAFE_F00D, 2);
            end
        join
        op(1'b0, 11'h014, 2'b10, 1'b0, 32'h0, 2, rd); chk("ld_word_lit", rd, 32'hCAFE_F00D);
        op(1'b0, 11'h00C, 2'b10, 1'b0, 32'h0, 2, rd); chk("sb_lit", rd, 32'hBEEF_A544);

        model_ld(9'd6, 32'h1234_5678);
        fork
            ld_drive(9'd6, 32'h1234_5678, 0);
            op(1'b0, 11'h018, 2'b10, 1'b0, 32'h0, 3, rd);
        join
        chk("ld_wins_lit", rd, 32'h1234_5678);

        i_req = 1'b1; i_we = 1'b1; i_addr = 11'h010; i_size = 2'b00; i_wdata = 32'h55;
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_stall", 32'(o_stall), 32'h0);
        chk("async_rst_rdata", o_rdata, 32'h0);
        chk("async_rst_strobes", {29'h0, o_rvalid, o_ld_gnt, o_mem_we}, 32'h0);
        i_req = 1'b0; i_we = 1'b0;
        #7;
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        op(1'b0, 11'h010, 2'b10, 1'b0, 32'h0, 2, rd); chk("rst_no_write", rd, 32'hDEAD_BEEF);

        repeat (2) @(posedge i_clk);
        chk("pending_reads", exp_rd.size(), 0);
        chk("pending_writes", exp_wa.size(), 0);
        chk("pending_misaligned", exp_mis, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Sequencing controller in front of the single-port, word-wide data RAM of the RV32IC core.
- Turns MEM-stage byte, halfword and word loads/stores into RAM word accesses. Sub-word stores use read-modify-write; loads are lane-extracted and sign- or zero-extended.
- Shares the RAM with a boot/debug loader write port and stalls the pipeline while a multi-cycle sequence runs.

Parameters:
- ADDR_WIDTH, 9, word-address width of the RAM.
- DATA_WIDTH, 32, RAM word width; fixed at 32 for RV32.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_req  in  1  MEM-stage memory op valid. Held stable with all fields while o_stall=1.
- i_we  in  1  1=store, 0=load.
- i_addr  in  ADDR_WIDTH+2  byte address.
- i_size  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
- i_unsigned  in  1  zero-extend loads (LBU/LHU).
- i_wdata  in  32  store data, right-aligned.
- o_stall  out  1  hold the pipeline.
- o_rdata  out  32  extended load result.
- o_rvalid  out  1  o_rdata valid this cycle.
- o_misaligned  out  1  one-cycle misaligned-access flag.
- i_ld_req  in  1  loader write request.
- i_ld_addr  in  ADDR_WIDTH  loader word address.
- i_ld_wdata  in  32  loader write data.
- o_ld_gnt  out  1  loader write performed this cycle.
- o_mem_we  out  1  RAM write enable.
- o_mem_addr  out  ADDR_WIDTH  RAM word address.
- o_mem_wdata  out  32  RAM write data.
- i_mem_rdata  in  32  RAM read data: registered, one-cycle latency, old contents on a same-cycle write.

Behaviour:
- Reset:
  - State goes to IDLE.
  - o_rdata, merge register and captured address/size are cleared to 0.
  - o_rvalid, o_misaligned, o_ld_gnt and o_mem_we are 0.
  - Reset mid-sequence abandons the sequence; no write is issued after reset release.
- Addressing:
  - Word address = i_addr[ADDR_WIDTH+1:2]. Byte lane = i_addr[1:0], little-endian.
  - Misaligned: half with i_addr[0]=1, or word with i_addr[1:0]!=0.
- States: IDLE, RD_WAIT, LD_DONE, RMW_MERGE, RMW_WR.
- IDLE priority 1, i_ld_req=1:
  - o_mem_we=1, address/data from the loader port, o_ld_gnt=1. Stay in IDLE.
  - o_stall=i_req.
- IDLE priority 2, i_req=1 and misaligned:
  - No RAM access. o_misaligned=1 for one cycle, o_stall=0. Stay in IDLE.
- IDLE priority 3, word store:
  - o_mem_we=1, o_mem_wdata=i_wdata, o_stall=0. Single cycle; stay in IDLE.
- IDLE priority 4, load:
  - Drive the read address, o_stall=1, go to RD_WAIT.
- IDLE priority 5, byte/half store:
  - Drive the read address, o_stall=1, go to RMW_MERGE.
- RD_WAIT:
  - Extract the lane from i_mem_rdata, extend, register into o_rdata. o_stall=1, go to LD_DONE.
- LD_DONE:
  - o_rvalid=1, o_stall=0, go to IDLE. The held request must not restart.
  - Load latency: 3 cycles, 2 of them stalled.
- RMW_MERGE:
  - Merge = i_mem_rdata with the addressed byte(s) replaced by i_wdata[7:0] or [15:0].
  - Register the merge, o_stall=1, go to RMW_WR.
- RMW_WR:
  - o_mem_we=1, o_mem_wdata=merge register, address from captured word address.
  - o_stall=0, go to IDLE. 3 cycles total.
- Loader arbitration:
  - Loader is never granted outside IDLE; i_ld_req waits and o_ld_gnt=0.
  - Loader wins over a new core request in IDLE.
- Sign extension: byte takes bit 7, half takes bit 15, unless i_unsigned=1. Word loads ignore i_unsigned.
- o_rvalid and o_misaligned are single-cycle pulses. o_rdata holds its value until the next load completes.
- Hold rule:
  - Address/size/data are captured in IDLE and used by later states.
  - Changes on the core inputs after IDLE are ignored until return to IDLE.

Test Plan:
- RAM[3]=0x8899AABB, LB at byte addr 0x00E, i_unsigned=0 -> o_stall high 2 cycles; 3rd cycle o_rvalid=1, o_rdata=0xFFFFFF99. Same access as LBU -> 0x00000099.
- RAM[3]=0x11223344, SH i_wdata=0x0000BEEF at addr 0x00E -> RMW write cycle 3 with o_mem_wdata=0xBEEF3344. Following LW addr 0x00C -> 0xBEEF3344.
- SW 0xDEADBEEF at addr 0x010 -> o_mem_we=1, o_mem_addr=4 same cycle, o_stall never high. LW back -> 0xDEADBEEF.
- LH at addr 0x001 -> o_misaligned=1 for exactly 1 cycle, no write, o_stall=0. Same for SW at 0x012, with RAM[4] unchanged.
- i_ld_req (addr 5, data 0xCAFEF00D) during an SB in RMW_MERGE -> o_ld_gnt=0 until the SB completes, then 1 in the next IDLE cycle. Simultaneous i_req and i_ld_req in IDLE -> loader granted, o_stall=1 that cycle.
- Assert i_rst_n=0 asynchronously in RMW_MERGE -> outputs clear immediately, RAM word unchanged after release, state IDLE.
